// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, divider
// state encoding and the reset/write-enable levels used across the pipeline.
package hilo_muldiv_unit_pkg;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;

  typedef enum logic [2:0] {
    OP_MTHI  = 3'b000,
    OP_MTLO  = 3'b001,
    OP_MULT  = 3'b010,
    OP_MULTU = 3'b011,
    OP_DIV   = 3'b100,
    OP_DIVU  = 3'b101,
    OP_MADD  = 3'b110,
    OP_MSUB  = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/hilo_muldiv_unit_div_core.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle on
// magnitudes, signs reapplied on the combinational result outputs.
module hilo_muldiv_unit_div_core
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_cancel,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem
);

  div_state_t       r_state;
  div_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_divisor;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_step;

  assign w_a_neg = i_signed & i_dividend[WIDTH-1];
  assign w_b_neg = i_signed & i_divisor[WIDTH-1];
  assign w_a_abs = w_a_neg ? (~i_dividend + {{(WIDTH-1){1'b0}}, 1'b1}) : i_dividend;
  assign w_b_abs = w_b_neg ? (~i_divisor + {{(WIDTH-1){1'b0}}, 1'b1}) : i_divisor;

  // Dividend bits stream out of the top of r_quot while quotient bits fill the bottom.
  assign w_shift    = {r_rem, r_quot[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, r_divisor};
  assign w_qbit     = ~w_trial[WIDTH];
  assign w_rem_step = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_nxt = ST_DIV;
      ST_DIV: begin
        if (i_cancel) w_state_nxt = ST_IDLE;
        else if (r_cnt == CNT_W'(WIDTH - 1)) w_state_nxt = ST_FIX;
      end
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_cnt     <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else if (r_state == ST_IDLE && i_start) begin
      r_cnt     <= '0;
      r_quot    <= w_a_abs;
      r_rem     <= '0;
      r_divisor <= w_b_abs;
      r_neg_q   <= w_a_neg ^ w_b_neg;
      r_neg_r   <= w_a_neg;
    end else if (r_state == ST_DIV && !i_cancel) begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_quot <= {r_quot[WIDTH-2:0], w_qbit};
      r_rem  <= w_rem_step;
    end
  end

  // The most-negative / -1 case falls out naturally: magnitude 2^(W-1) with no sign flip.
  assign o_quot  = r_neg_q ? (~r_quot + {{(WIDTH-1){1'b0}}, 1'b1}) : r_quot;
  assign o_rem   = r_neg_r ? (~r_rem + {{(WIDTH-1){1'b0}}, 1'b1}) : r_rem;
  assign o_busy  = (r_state != ST_IDLE);
  assign o_valid = (r_state == ST_FIX) && !i_cancel;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO architectural registers with single-cycle multiply/accumulate and
// MTHI/MTLO, plus an iterative divider that holds busy while in flight.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_div_zero;

  op_t                w_op;
  logic               w_accept;
  logic               w_is_div;
  logic               w_div_start;
  logic               w_div_busy;
  logic               w_div_valid;
  logic [WIDTH-1:0]   w_div_quot;
  logic [WIDTH-1:0]   w_div_rem;
  logic [2*WIDTH-1:0] w_hilo;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;

  assign w_op        = op_t'(op);
  assign w_accept    = start && !w_div_busy;
  assign w_is_div    = (w_op == OP_DIV) || (w_op == OP_DIVU);
  assign w_div_start = w_accept && w_is_div && (opb != '0);
  assign w_hilo      = {r_hi, r_lo};

  // Low 2W bits of the product of sign-extended operands equal the signed product.
  assign w_prod_s = {{WIDTH{opa[WIDTH-1]}}, opa} * {{WIDTH{opb[WIDTH-1]}}, opb};
  assign w_prod_u = {{WIDTH{1'b0}}, opa} * {{WIDTH{1'b0}}, opb};

  hilo_muldiv_unit_div_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_div_core (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_signed   (w_op == OP_DIV),
    .i_dividend (opa),
    .i_divisor  (opb),
    .i_cancel   (cancel),
    .o_busy     (w_div_busy),
    .o_valid    (w_div_valid),
    .o_quot     (w_div_quot),
    .o_rem      (w_div_rem)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      if (w_div_valid) begin
        r_hi   <= w_div_rem;
        r_lo   <= w_div_quot;
        r_done <= WRITE_ENABLE;
      end else if (w_accept) begin
        case (w_op)
          OP_MTHI: begin
            r_hi   <= opa;
            r_done <= WRITE_ENABLE;
          end
          OP_MTLO: begin
            r_lo   <= opa;
            r_done <= WRITE_ENABLE;
          end
          OP_MULT: begin
            {r_hi, r_lo} <= w_prod_s;
            r_done       <= WRITE_ENABLE;
          end
          OP_MULTU: begin
            {r_hi, r_lo} <= w_prod_u;
            r_done       <= WRITE_ENABLE;
          end
          OP_MADD: begin
            {r_hi, r_lo} <= w_hilo + w_prod_s;
            r_done       <= WRITE_ENABLE;
          end
          OP_MSUB: begin
            {r_hi, r_lo} <= w_hilo - w_prod_s;
            r_done       <= WRITE_ENABLE;
          end
          OP_DIV, OP_DIVU: begin
            if (opb == '0) begin
              r_done     <= WRITE_ENABLE;
              r_div_zero <= WRITE_ENABLE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign busy     = w_div_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi_o     = r_hi;
  assign lo_o     = r_lo;

endmodule
